cube_frame_arbiter: RTL and testbench

//  Parametrised frame source arbiter and double buffer for an N x N x N LED cube. Selects one of
//  NUM_SRC streaming frame sources or a built-in static pattern. Captures frames into a back buffer
//  and swaps them into the front buffer only on display scan completion, so the display never tears.

---
 rtl/cube_frame_arbiter_if.sv | 30 +++
 rtl/cube_frame_arbiter.sv | 139 +++++++++++++
 tb/tb_cube_frame_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cube_frame_arbiter_if.sv
// Frame bus between frame producers, the arbiter and the display scan block.
// The slave modport is the arbiter side. The master modport is the producer/display side.
interface cube_frame_arbiter_if #(
  parameter int unsigned CUBE_N  = 8,
  parameter int unsigned NUM_SRC = 2
);
  localparam int unsigned FRAME_W = CUBE_N * CUBE_N * CUBE_N;

  logic [NUM_SRC*FRAME_W-1:0] src_frame_flat;
  logic [NUM_SRC-1:0]         src_valid;
  logic                       scan_done;
  logic [FRAME_W-1:0]         frame_flat;
  logic                       swap;

  modport slave (
    input  src_frame_flat,
    input  src_valid,
    input  scan_done,
    output frame_flat,
    output swap
  );

  modport master (
    output src_frame_flat,
    output src_valid,
    output scan_done,
    input  frame_flat,
    input  swap
  );
endinterface

// File: rtl/cube_frame_arbiter.sv
// Frame source arbiter and tear-free double buffer for an N x N x N LED cube.
// The back buffer is swapped into the front buffer only when a display scan completes.
module cube_frame_arbiter #(
  parameter int unsigned CUBE_N  = 8,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned SRC_W   = 1,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned DROP_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               static_en_i,
  input  logic [3:0]         static_sel_i,
  input  logic [SRC_W-1:0]   src_sel_i,
  input  logic               freeze_i,
  cube_frame_arbiter_if.slave bus,
  output logic [CNT_W-1:0]   frame_cnt_o,
  output logic [DROP_W-1:0]  drop_cnt_o
);
  localparam int unsigned FRAME_W = CUBE_N * CUBE_N * CUBE_N;
  localparam int unsigned CFG_W   = 1 + 4 + SRC_W;

  // Bit index = z*N*N + y*N + x.
  function automatic logic [FRAME_W-1:0] pattern(input logic [3:0] sel);
    logic [FRAME_W-1:0] p;
    int unsigned        idx;
    int unsigned        n_bnd;
    p = '0;
    for (int unsigned z = 0; z < CUBE_N; z++) begin
      for (int unsigned y = 0; y < CUBE_N; y++) begin
        for (int unsigned x = 0; x < CUBE_N; x++) begin
          idx   = z * CUBE_N * CUBE_N + y * CUBE_N + x;
          n_bnd = 0;
          if (x == 0 || x == CUBE_N - 1) n_bnd++;
          if (y == 0 || y == CUBE_N - 1) n_bnd++;
          if (z == 0 || z == CUBE_N - 1) n_bnd++;
          case (sel)
            4'd0:    p[idx] = 1'b0;
            4'd1:    p[idx] = 1'b1;
            4'd2:    p[idx] = ((x + y + z) & 32'd1) != 0;
            4'd3:    p[idx] = n_bnd >= 2;
            default: p[idx] = (z + 4) == 32'(sel);
          endcase
        end
      end
    end
    return p;
  endfunction

  logic [CFG_W-1:0]   cfg_d, cfg_q;
  logic               load_d, load_q;
  logic [FRAME_W-1:0] back_d, back_q;
  logic [FRAME_W-1:0] front_d, front_q;
  logic               pending_d, pending_q;
  logic               swap_d, swap_q;
  logic [CNT_W-1:0]   frame_cnt_d, frame_cnt_q;
  logic [DROP_W-1:0]  drop_cnt_d, drop_cnt_q;

  logic               cfg_chg;
  logic               sel_valid;
  logic [FRAME_W-1:0] sel_frame;
  logic [FRAME_W-1:0] static_pat;
  logic               cap_stream, cap_static, cap, do_swap;

  // Out-of-range src_sel selects nothing, so no capture can happen.
  always_comb begin
    sel_valid = 1'b0;
    sel_frame = '0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      if (32'(src_sel_i) == s) begin
        sel_valid = bus.src_valid[s];
        sel_frame = bus.src_frame_flat[s*FRAME_W +: FRAME_W];
      end
    end
  end

  assign static_pat = pattern(static_sel_i);

  always_comb begin
    cfg_d      = {static_en_i, static_sel_i, src_sel_i};
    cfg_chg    = cfg_d != cfg_q;
    cap_stream = sel_valid & ~static_en_i & ~cfg_chg;
    // Static pattern loads once, in the cycle after the config settles.
    cap_static = load_q & ~cfg_chg;
    cap        = cap_stream | cap_static;
    do_swap    = bus.scan_done & pending_q & ~freeze_i & ~cfg_chg;
    load_d     = cfg_chg & static_en_i;
    swap_d     = do_swap;

    back_d = back_q;
    if (cap_static) begin
      back_d = static_pat;
    end else if (cap_stream) begin
      back_d = sel_frame;
    end

    front_d = do_swap ? back_q : front_q;

    pending_d   = 1'b0;
    frame_cnt_d = '0;
    drop_cnt_d  = '0;
    if (!cfg_chg) begin
      pending_d   = cap | (pending_q & ~do_swap);
      frame_cnt_d = frame_cnt_q + CNT_W'(do_swap);
      drop_cnt_d  = drop_cnt_q;
      if (cap && pending_q && !do_swap && !(&drop_cnt_q)) begin
        drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q       <= '0;
      load_q      <= 1'b0;
      back_q      <= '0;
      front_q     <= '0;
      pending_q   <= 1'b0;
      swap_q      <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      cfg_q       <= cfg_d;
      load_q      <= load_d;
      back_q      <= back_d;
      front_q     <= front_d;
      pending_q   <= pending_d;
      swap_q      <= swap_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign bus.frame_flat = front_q;
  assign bus.swap       = swap_q;
  assign frame_cnt_o    = frame_cnt_q;
  assign drop_cnt_o     = drop_cnt_q;

endmodule

// File: tb/tb_cube_frame_arbiter.sv
// Bench for cube_frame_arbiter: static pattern table, stream capture, drops, freeze and reconfig.
// Frames expected at each swap are queued by the stimulus and checked when swap fires.
module tb_cube_frame_arbiter;
  localparam int unsigned N   = 8;
  localparam int unsigned NS  = 2;
  localparam int unsigned SW  = 2;
  localparam int unsigned CW  = 32;
  localparam int unsigned DW  = 4;
  localparam int unsigned FW  = N * N * N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          static_en;
  logic [3:0]    static_sel;
  logic [SW-1:0] src_sel;
  logic          freeze;
  logic [CW-1:0] frame_cnt;
  logic [DW-1:0] drop_cnt;

  cube_frame_arbiter_if #(.CUBE_N(N), .NUM_SRC(NS)) bus ();

  cube_frame_arbiter #(
    .CUBE_N (N),
    .NUM_SRC(NS),
    .SRC_W  (SW),
    .CNT_W  (CW),
    .DROP_W (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .static_en_i (static_en),
    .static_sel_i(static_sel),
    .src_sel_i   (src_sel),
    .freeze_i    (freeze),
    .bus         (bus),
    .frame_cnt_o (frame_cnt),
    .drop_cnt_o  (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [FW-1:0] exp_q[$];

  typedef struct {
    logic [3:0]  sel;
    int unsigned pop;
  } vec_t;
  vec_t tbl[8];

  task automatic check_int(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_frame(input string name, input logic [FW-1:0] act,
                             input logic [FW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference patterns built by decomposing each bit index.
  function automatic logic [FW-1:0] model_pat(input logic [3:0] sel);
    logic [FW-1:0] p;
    int x, y, z, nb;
    int s;
    p = '0;
    s = int'(sel);
    for (int i = 0; i < int'(FW); i++) begin
      x  = i % int'(N);
      y  = (i / int'(N)) % int'(N);
      z  = i / int'(N * N);
      nb = ((x == 0 || x == int'(N) - 1) ? 1 : 0) + ((y == 0 || y == int'(N) - 1) ? 1 : 0)
         + ((z == 0 || z == int'(N) - 1) ? 1 : 0);
      if (s == 1) p[i] = 1'b1;
      else if (s == 2) p[i] = ((x + y + z) % 2) == 1;
      else if (s == 3) p[i] = nb >= 2;
      else if (s >= 4) p[i] = (z == s - 4);
    end
    return p;
  endfunction

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int i = 0; i < int'(FW / 32); i++) f[i*32 +: 32] = $urandom();
    return f;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.swap) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_swap: got swap=1, expected no swap");
      end else begin
        check_frame("swap_frame", bus.frame_flat, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int src, input logic [FW-1:0] f);
    bus.src_frame_flat[src*FW +: FW] = f;
    bus.src_valid[src] = 1'b1;
    tick();
    bus.src_valid = '0;
  endtask

  task automatic pulse_scan();
    bus.scan_done = 1'b1;
    tick();
    bus.scan_done = 1'b0;
  endtask

  task automatic expect_swap(input logic [FW-1:0] f);
    exp_q.push_back(f);
    pulse_scan();
    @(negedge clk);
    #1;
    check_int("swap_seen", 64'(exp_q.size()), 64'd0);
  endtask

  logic [FW-1:0] fa, fb, fc, fd, fe, fx, held;
  int unsigned   pop;
  int unsigned   exp_cnt;

  initial begin
    static_en          = 1'b1;
    static_sel         = 4'd1;
    src_sel            = '0;
    freeze             = 1'b0;
    bus.src_frame_flat = '0;
    bus.src_valid      = '0;
    bus.scan_done      = 1'b0;
    tbl[0] = '{4'd0, 0};
    tbl[1] = '{4'd1, 512};
    tbl[2] = '{4'd2, 256};
    tbl[3] = '{4'd3, 80};
    tbl[4] = '{4'd4, 64};
    tbl[5] = '{4'd11, 64};
    tbl[6] = '{4'd12, 0};
    tbl[7] = '{4'd15, 0};

    #3;
    check_frame("reset_frame", bus.frame_flat, '0);
    check_int("reset_swap", 64'(bus.swap), 64'd0);
    check_int("reset_cnt", 64'(frame_cnt), 64'd0);
    check_int("reset_drop", 64'(drop_cnt), 64'd0);
    #14 rst = 1'b0;

    // T1: static all-on loads after the implicit config change at reset release.
    tick();
    tick();
    expect_swap({FW{1'b1}});
    check_int("t1_cnt", 64'(frame_cnt), 64'd1);

    for (int i = 0; i < 8; i++) begin
      static_sel = tbl[i].sel;
      tick();
      check_int("tbl_cnt_clr", 64'(frame_cnt), 64'd0);
      tick();
      expect_swap(model_pat(tbl[i].sel));
      pop = $countones(bus.frame_flat);
      check_int("tbl_pop", 64'(pop), 64'(tbl[i].pop));
      check_int("tbl_cnt", 64'(frame_cnt), 64'd1);
    end

    // T2: stream from source 1.
    static_en = 1'b0;
    src_sel   = 2'd1;
    tick();
    tick();
    fa = rand_frame();
    send(1, fa);
    repeat (4) tick();
    expect_swap(fa);
    exp_cnt = 1;
    check_int("t2_drop", 64'(drop_cnt), 64'd0);
    check_int("t2_cnt", 64'(frame_cnt), 64'(exp_cnt));

    // Capture on a scan_done cycle with nothing pending must not bypass.
    fx = rand_frame();
    bus.src_frame_flat[FW +: FW] = fx;
    bus.src_valid = 2'b10;
    bus.scan_done = 1'b1;
    tick();
    bus.src_valid = '0;
    bus.scan_done = 1'b0;
    tick();
    check_frame("nobypass_front", bus.frame_flat, fa);
    expect_swap(fx);
    exp_cnt++;

    // T3: two overwrites before the swap.
    fa = rand_frame();
    fb = rand_frame();
    fc = rand_frame();
    send(1, fa);
    send(1, fb);
    send(1, fc);
    check_frame("t3_hold", bus.frame_flat, fx);
    expect_swap(fc);
    exp_cnt++;
    check_int("t3_drop", 64'(drop_cnt), 64'd2);
    check_int("t3_cnt", 64'(frame_cnt), 64'(exp_cnt));

    // T4: capture and swap in the same cycle.
    fc = rand_frame();
    fd = rand_frame();
    send(1, fc);
    exp_q.push_back(fc);
    bus.src_frame_flat[FW +: FW] = fd;
    bus.src_valid = 2'b10;
    bus.scan_done = 1'b1;
    tick();
    bus.src_valid = '0;
    bus.scan_done = 1'b0;
    @(negedge clk);
    #1;
    check_int("t4_swap_seen", 64'(exp_q.size()), 64'd0);
    exp_cnt++;
    check_int("t4_drop", 64'(drop_cnt), 64'd2);
    expect_swap(fd);
    exp_cnt++;
    check_int("t4_cnt", 64'(frame_cnt), 64'(exp_cnt));

    // T5: freeze holds the front through scans.
    freeze = 1'b1;
    fe = rand_frame();
    send(1, fe);
    repeat (3) begin
      pulse_scan();
      tick();
    end
    check_frame("t5_frozen", bus.frame_flat, fd);
    check_int("t5_cnt_frozen", 64'(frame_cnt), 64'(exp_cnt));
    freeze = 1'b0;
    tick();
    expect_swap(fe);
    exp_cnt++;

    // Drop counter saturates at all-ones.
    for (int i = 0; i < 20; i++) begin
      fx = rand_frame();
      send(1, fx);
    end
    check_int("drop_sat", 64'(drop_cnt), 64'd15);
    expect_swap(fx);
    exp_cnt++;
    check_int("sat_cnt", 64'(frame_cnt), 64'(exp_cnt));

    // T6: reconfiguration while pending clears state and holds the front.
    held = fx;
    send(1, rand_frame());
    src_sel = 2'd0;
    tick();
    check_int("t6_cnt_clr", 64'(frame_cnt), 64'd0);
    check_int("t6_drop_clr", 64'(drop_cnt), 64'd0);
    pulse_scan();
    tick();
    check_frame("t6_held", bus.frame_flat, held);
    src_sel = 2'd3;
    bus.src_frame_flat = {rand_frame(), rand_frame()};
    bus.src_valid = 2'b11;
    repeat (3) tick();
    bus.src_valid = '0;
    pulse_scan();
    tick();
    pulse_scan();
    tick();
    check_frame("t6_oob_held", bus.frame_flat, held);
    check_int("t6_oob_drop", 64'(drop_cnt), 64'd0);
    check_int("t6_oob_cnt", 64'(frame_cnt), 64'd0);

    // Asynchronous reset clears the front without a clock edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_frame("async_rst_front", bus.frame_flat, '0);
    check_int("async_rst_swap", 64'(bus.swap), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
